// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// MIPS_BNE_EN (when defined) enables the bne instruction path.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } statetype;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: aluop plus R-type funct field to ALU F code.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter logic [2:0] FUNCT_DEFAULT_F = 3'b010
) (
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = F_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = F_ADD;
            ALUOP_SUB: alucontrol = F_SUB;
            default: begin
                case (funct)
                    FN_ADD:  alucontrol = F_ADD;
                    FN_SUB:  alucontrol = F_SUB;
                    FN_AND:  alucontrol = F_AND;
                    FN_OR:   alucontrol = F_OR;
                    FN_SLT:  alucontrol = F_SLT;
                    default: alucontrol = FUNCT_DEFAULT_F;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the datapath plus ALU decoder.
// MIPS_BNE_EN (when defined) adds a BNEEX state for op 000101.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter logic [2:0] FUNCT_DEFAULT_F = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite
);

    statetype state;
    aluop_t   aluop;
    logic     pcwrite, branch, bne;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= RTYPEEX;
                        OP_BEQ:       state <= BEQEX;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JEX;
`ifdef MIPS_BNE_EN
                        OP_BNE:       state <= BNEEX;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state <= MEMWB;
                RTYPEEX: state <= RTYPEWB;
                ADDIEX:  state <= ADDIWB;
                // Terminal states and any unused encoding fall back to FETCH.
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        aluop    = ALUOP_ADD;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        case (state)
            FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; alusrcb = 2'b01; end
            DECODE:  alusrcb = 2'b11;
            MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin regwrite = 1'b1; memtoreg = 1'b1; end
            MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
            RTYPEEX: begin alusrca = 1'b1; aluop = ALUOP_FUNCT; end
            RTYPEWB: begin regwrite = 1'b1; regdst = 1'b1; end
            BEQEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; end
            ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
            ADDIWB:  regwrite = 1'b1;
            JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef MIPS_BNE_EN
            BNEEX:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; bne = 1'b1; end
`endif
            default: ;
        endcase
        // Reset is honoured combinationally so no write escapes on the reset edge itself.
        if (reset) begin
            aluop    = ALUOP_ADD;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            bne      = 1'b0;
        end
    end

`ifdef MIPS_BNE_EN
    assign pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
    assign pcen = pcwrite | (branch & zero) | (bne & 1'b0);
`endif

    alu_decoder #(.FUNCT_DEFAULT_F(FUNCT_DEFAULT_F)) u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: per-instruction output schedule model vs the controller.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite)
    );

    always #5 clk = ~clk;

    wire [15:0] got = {alucontrol, alusrca, alusrcb, pcsrc, pcen, iord,
                       memwrite, irwrite, regdst, memtoreg, regwrite};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (op=%b funct=%b zero=%b t=%0t)",
                     tag, obs, exp, op, funct, zero, $time);
        end
    endtask

    function automatic logic [15:0] mk(logic [2:0] alu, logic sa, logic [1:0] sb, logic [1:0] ps,
                                       logic pe, logic io, logic mw, logic iw, logic rd,
                                       logic mr, logic rw);
        return {alu, sa, sb, ps, pe, io, mw, iw, rd, mr, rw};
    endfunction

    function automatic logic [2:0] rfn(logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit bne_on();
`ifdef MIPS_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycle count of one instruction, from the per-opcode timing rules.
    function automatic int ilen(logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            6'b000101: return bne_on() ? 3 : 2;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction.
    function automatic logic [15:0] model(logic [5:0] o, logic [5:0] fn, int k, logic z);
        if (k == 0) return mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0);
        if (k == 1) return mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        case (o)
            6'b100011: case (k)
                2: return mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
                3: return mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0);
                default: return mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1);
            endcase
            6'b101011: if (k == 2) return mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
                       else        return mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0);
            6'b000000: if (k == 2) return mk(rfn(fn), 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
                       else        return mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1);
            6'b001000: if (k == 2) return mk(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0);
                       else        return mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
            6'b000100: return mk(3'b110, 1, 2'b00, 2'b01, z, 0, 0, 0, 0, 0, 0);
            6'b000101: return mk(3'b110, 1, 2'b00, 2'b01, ~z, 0, 0, 0, 0, 0, 0);
            6'b000010: return mk(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0);
            default:   return 16'hxxxx;
        endcase
    endfunction

    localparam logic [15:0] RST_OUT = 16'b010_0_01_00_0_0_0_0_0_0_0;

    // One cycle: drive on the falling edge, sample mid low phase.
    task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] fn, input logic z);
        @(negedge clk);
        reset = r; op = o; funct = fn; zero = z;
        #2;
    endtask

    // zmode: 0/1 force zero, 2 random each cycle. ncyc < 0 runs the whole instruction.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] fn,
                             input int zmode, input int ncyc);
        int n = (ncyc < 0) ? ilen(o) : ncyc;
        for (int k = 0; k < n; k++) begin
            logic z = (zmode == 2) ? logic'($urandom_range(0, 1)) : logic'(zmode);
            cyc(1'b0, o, fn, z);
            chk($sformatf("%s_c%0d", tag, k), got, model(o, fn, k, z));
        end
    endtask

    logic [5:0] ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b001000, 6'b000010, 6'b000101, 6'b111111};
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
        cyc(1'b1, 6'b000000, 6'b0, 1'b0);
        chk("reset0", got, RST_OUT);
        cyc(1'b1, 6'b100011, 6'b0, 1'b1);
        chk("reset1", got, RST_OUT);

        run_instr("lw", 6'b100011, 6'b0, 2, -1);
        run_instr("sw", 6'b101011, 6'b0, 2, -1);
        run_instr("slt", 6'b000000, 6'b101010, 2, -1);
        run_instr("rdef", 6'b000000, 6'b111111, 2, -1);
        run_instr("beq_z1", 6'b000100, 6'b0, 1, -1);
        run_instr("beq_z0", 6'b000100, 6'b0, 0, -1);
        run_instr("bne_z0", 6'b000101, 6'b0, 0, -1);
        run_instr("bne_z1", 6'b000101, 6'b0, 1, -1);
        run_instr("addi", 6'b001000, 6'b0, 2, -1);
        run_instr("j", 6'b000010, 6'b0, 2, -1);
        run_instr("ill", 6'b111111, 6'b0, 2, -1);

        // Reset raised in the RTYPEEX cycle's aftermath: RTYPEWB must not write.
        run_instr("rmid", 6'b000000, 6'b100100, 2, 3);
        cyc(1'b1, 6'b000000, 6'b100100, 1'b1);
        chk("rst_mid0", got, RST_OUT);
        cyc(1'b1, 6'b000000, 6'b100100, 1'b1);
        chk("rst_mid1", got, RST_OUT);
        run_instr("post_rst", 6'b000000, 6'b100101, 2, -1);

        for (int i = 0; i < 200; i++) begin
            int oi = $urandom_range(0, 8);
            logic [5:0] o = (oi == 8) ? 6'($urandom) : ops[oi];
            logic [5:0] fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run_instr("rnd", o, fn, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
